// File: rtl/cram_pkg.sv
// Shared types, instruction layout and helpers for the compute-RAM
// macro-command sequencer.
package cram_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_XOR  = 4'd2,
        OP_NAND = 4'd3,
        OP_NOR  = 4'd4,
        OP_XNOR = 4'd5,
        OP_ADD  = 4'd6,
        OP_CPY  = 4'd7,
        OP_INV  = 4'd8,
        OP_EQU  = 4'd9,
        OP_LDT  = 4'd10,
        OP_STC  = 4'd11,
        OP_STT  = 4'd12,
        OP_SC   = 4'd13,
        OP_CC   = 4'd14,
        OP_C2T  = 4'd15
    } op_type_e;

    localparam int EN_HI  = 31;
    localparam int EN_LO  = 28;
    localparam int OPC_HI = 27;
    localparam int OPC_LO = 24;
    localparam int A_HI   = 23;
    localparam int A_LO   = 16;
    localparam int B_HI   = 15;
    localparam int B_LO   = 8;
    localparam int D_HI   = 7;
    localparam int D_LO   = 0;

    localparam logic [3:0] EN_EXEC = 4'b1000;
    localparam logic [3:0] EN_TAG  = 4'b0001;

    typedef enum logic [1:0] {
        M_ADD   = 2'd0,
        M_ADDC  = 2'd1,
        M_LOGIC = 2'd2,
        M_RAW   = 2'd3
    } macro_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_RUN,
        S_POST,
        S_DONE
    } state_e;

    // True when base+width+extra-1 stays within the 256 columns.
    function automatic logic range_ok(
        input logic [7:0] base,
        input logic [8:0] width,
        input logic       extra
    );
        logic [8:0] top;
        top = {1'b0, base} + width + {8'd0, extra};
        return top <= 9'd256;
    endfunction

    function automatic logic [31:0] mk_inst(
        input logic       tag,
        input logic [3:0] opc,
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] d
    );
        logic [31:0] i;
        i = '0;
        i[EN_HI:EN_LO]   = EN_EXEC | (tag ? EN_TAG : 4'b0000);
        i[OPC_HI:OPC_LO] = opc;
        i[A_HI:A_LO]     = a;
        i[B_HI:B_LO]     = b;
        i[D_HI:D_LO]     = d;
        return i;
    endfunction

endpackage

// File: rtl/cram_seq.sv
// Expands vector macro-commands into bit-serial array micro-ops and
// gates the host SRAM port while a command is in flight.
module cram_seq
    import cram_pkg::*;
#(
    parameter int Row       = 128,
    parameter int Col       = 256,
    parameter int WordSize  = 32,
    parameter int MaxWidth  = 32,
    parameter int AddrWidth = $clog2(Row * Col / WordSize),
    localparam int WW       = $clog2(MaxWidth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [3:0]           cmd_sub_i,
    input  logic [WW-1:0]        cmd_width_i,
    input  logic                 cmd_tag_i,
    input  logic [7:0]           cmd_a_i,
    input  logic [7:0]           cmd_b_i,
    input  logic [7:0]           cmd_d_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [31:0]          inst_o,
    input  logic                 mem_req_i,
    input  logic                 mem_we_i,
    input  logic [AddrWidth-1:0] mem_addr_i,
    input  logic [WordSize-1:0]  mem_wdata_i,
    output logic                 mem_gnt_o,
    output logic [WordSize-1:0]  mem_rdata_o,
    output logic                 we_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [WordSize-1:0]  data_o,
    input  logic [WordSize-1:0]  data_i
);

    state_e        state_q, state_d;
    logic [31:0]   inst_q, inst_d;
    logic [WW-1:0] cnt_q, cnt_d, wm1_q, nxt;
    logic          err_q, err_d;
    macro_op_e     op_q, op_in;
    logic [3:0]    sub_q;
    logic          tag_q;
    logic [7:0]    a_q, b_q, d_q;

    logic       idle, accept, cmd_err;
    logic       unary_in, unary_q, sub_legal, need_b;
    logic [8:0] w_in;
    logic [3:0] run_opc;

    assign idle = (state_q == S_IDLE);

    assign mem_gnt_o   = mem_req_i & idle;
    assign we_o        = mem_gnt_o & mem_we_i;
    assign addr_o      = mem_addr_i;
    assign data_o      = mem_wdata_i;
    assign mem_rdata_o = data_i;

    assign cmd_ready_o = idle & ~mem_req_i;
    assign accept      = cmd_valid_i & cmd_ready_o;

    assign op_in     = macro_op_e'(cmd_op_i);
    assign w_in      = 9'(cmd_width_i) + 9'd1;
    assign unary_in  = (cmd_sub_i == OP_CPY) || (cmd_sub_i == OP_INV);
    assign unary_q   = (sub_q == OP_CPY) || (sub_q == OP_INV);
    assign sub_legal = (cmd_sub_i <= 4'd5) || unary_in;
    assign need_b    = !(op_in == M_LOGIC && unary_in);

    // RAW bypasses all checks; ADDC needs one extra column for carry-out.
    assign cmd_err = (op_in != M_RAW) &&
        (!range_ok(cmd_a_i, w_in, 1'b0) ||
         (need_b && !range_ok(cmd_b_i, w_in, 1'b0)) ||
         !range_ok(cmd_d_i, w_in, op_in == M_ADDC) ||
         (op_in == M_LOGIC && !sub_legal));

    assign nxt     = cnt_q + WW'(1);
    assign run_opc = (op_q == M_LOGIC) ? sub_q : OP_ADD;

    always_comb begin
        state_d = state_q;
        inst_d  = '0;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    err_d = cmd_err;
                    cnt_d = '0;
                    if (cmd_err) begin
                        state_d = S_DONE;
                    end else begin
                        unique case (op_in)
                            M_ADD, M_ADDC: begin
                                inst_d  = mk_inst(cmd_tag_i, OP_CC,
                                                  8'd0, 8'd0, 8'd0);
                                state_d = S_PRE;
                            end
                            M_LOGIC: begin
                                inst_d  = mk_inst(cmd_tag_i, cmd_sub_i,
                                                  cmd_a_i,
                                                  unary_in ? 8'd0 : cmd_b_i,
                                                  cmd_d_i);
                                state_d = S_RUN;
                            end
                            M_RAW: begin
                                inst_d  = mk_inst(cmd_tag_i, cmd_sub_i,
                                                  cmd_a_i, cmd_b_i, cmd_d_i);
                                state_d = S_POST;
                            end
                        endcase
                    end
                end
            end
            S_PRE: begin
                inst_d  = mk_inst(tag_q, OP_ADD, a_q, b_q, d_q);
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q == wm1_q) begin
                    if (op_q == M_ADDC) begin
                        inst_d  = mk_inst(tag_q, OP_STC, 8'd0, 8'd0,
                                          d_q + 8'(wm1_q) + 8'd1);
                        state_d = S_POST;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d  = nxt;
                    inst_d = mk_inst(tag_q, run_opc,
                                     a_q + 8'(nxt),
                                     unary_q ? 8'd0 : b_q + 8'(nxt),
                                     d_q + 8'(nxt));
                end
            end
            S_POST: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            inst_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            op_q    <= M_ADD;
            sub_q   <= '0;
            tag_q   <= 1'b0;
            wm1_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (accept) begin
                op_q  <= op_in;
                sub_q <= cmd_sub_i;
                tag_q <= cmd_tag_i;
                wm1_q <= cmd_width_i;
                a_q   <= cmd_a_i;
                b_q   <= cmd_b_i;
                d_q   <= cmd_d_i;
            end
        end
    end

    assign inst_o = inst_q;
    assign busy_o = !idle;
    assign done_o = (state_q == S_DONE);
    assign err_o  = done_o & err_q;

endmodule
